// File: rtl/dma_copy_engine_pkg.sv
// Shared DMA constants: register select codes, CTRL bit positions, MMIO map
// and the FSM state type.
package dma_copy_engine_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_SRC_FIXED = 1;
    localparam int CTRL_DST_FIXED = 2;
    localparam int CTRL_ABORT     = 3;

    localparam logic [15:0] DMA_SRC_ADDR     = 16'hFF20;
    localparam logic [15:0] DMA_DST_ADDR     = 16'hFF22;
    localparam logic [15:0] DMA_LEN_ADDR     = 16'hFF24;
    localparam logic [15:0] DMA_CONTROL_ADDR = 16'hFF26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FINISH
    } dma_state_e;

endpackage

// File: rtl/dma_copy_engine.sv
// Bus-master block copy of 16-bit words, one read then one write per word,
// configured through SRC/DST/LEN/CTRL registers.
//
// state  | meaning
// IDLE   | waiting for START; SRC/DST/LEN/CTRL writable
// RD     | read request at src counter outstanding
// WR     | write request at dst counter outstanding
// FINISH | transfer over; done pulse issued on leaving
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter logic [15:0] ADDR_STEP = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        reg_wr_en_i,
    input  logic [1:0]  reg_sel_i,
    input  logic [15:0] reg_data_i,
    output logic        dma_status_o,
    output logic        done_pulse_o,
    output logic        aborted_o,
    output logic [15:0] remaining_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    input  logic [15:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    dma_state_e  state_q;
    logic [15:0] src_reg_q, dst_reg_q, len_q;
    logic        src_fixed_q, dst_fixed_q;
    logic [15:0] src_q, dst_q, remaining_q;
    logic        abort_pend_q, zero_len_q;
    logic        busy_q, done_q, aborted_q;
    logic        bus_req_q, bus_we_q;
    logic [15:0] bus_addr_q, bus_wdata_q;

    logic        ctrl_wr, start_req, abort_req, abort_now;
    logic [15:0] src_d, dst_d, remaining_d;

    always_comb begin
        ctrl_wr     = reg_wr_en_i && (reg_sel_i == REG_CTRL);
        start_req   = ctrl_wr && reg_data_i[CTRL_START];
        abort_req   = ctrl_wr && reg_data_i[CTRL_ABORT];
        abort_now   = abort_pend_q || abort_req;
        remaining_d = remaining_q - 16'd1;
        src_d       = src_fixed_q ? src_q : src_q + ADDR_STEP;
        dst_d       = dst_fixed_q ? dst_q : dst_q + ADDR_STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            src_reg_q    <= '0;
            dst_reg_q    <= '0;
            len_q        <= '0;
            src_fixed_q  <= 1'b0;
            dst_fixed_q  <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            abort_pend_q <= 1'b0;
            zero_len_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else if (en_i) begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A zero-length START spends one decision cycle here so
                    // its done pulse lands two cycles after the START edge.
                    if (zero_len_q) begin
                        zero_len_q <= 1'b0;
                        state_q    <= ST_FINISH;
                    end else begin
                        if (reg_wr_en_i) begin
                            unique case (reg_sel_i)
                                REG_SRC:  src_reg_q <= reg_data_i;
                                REG_DST:  dst_reg_q <= reg_data_i;
                                REG_LEN:  len_q     <= reg_data_i;
                                REG_CTRL: begin
                                    src_fixed_q <= reg_data_i[CTRL_SRC_FIXED];
                                    dst_fixed_q <= reg_data_i[CTRL_DST_FIXED];
                                end
                            endcase
                        end
                        if (start_req) begin
                            aborted_q    <= 1'b0;
                            abort_pend_q <= 1'b0;
                            src_q        <= src_reg_q;
                            dst_q        <= dst_reg_q;
                            remaining_q  <= len_q;
                            if (len_q != 16'd0) begin
                                state_q    <= ST_RD;
                                busy_q     <= 1'b1;
                                bus_req_q  <= 1'b1;
                                bus_we_q   <= 1'b0;
                                bus_addr_q <= src_reg_q;
                            end else begin
                                zero_len_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (abort_req) abort_pend_q <= 1'b1;
                    if (bus_ack_i) begin
                        bus_wdata_q <= bus_rdata_i;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= dst_q;
                        state_q     <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (bus_ack_i) begin
                        remaining_q <= remaining_d;
                        src_q       <= src_d;
                        dst_q       <= dst_d;
                        bus_we_q    <= 1'b0;
                        if ((remaining_d == 16'd0) || abort_now) begin
                            state_q      <= ST_FINISH;
                            busy_q       <= 1'b0;
                            bus_req_q    <= 1'b0;
                            aborted_q    <= abort_now;
                            abort_pend_q <= 1'b0;
                        end else begin
                            state_q    <= ST_RD;
                            bus_addr_q <= src_d;
                        end
                    end else if (abort_req) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dma_status_o = busy_q;
    assign done_pulse_o = done_q && en_i;
    assign aborted_o    = aborted_q;
    assign remaining_o  = remaining_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: bus memory model with configurable wait
// states, transaction scoreboard against an arithmetic copy model.
module tb_dma_copy_engine;
    import dma_copy_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        reg_wr_en = 1'b0;
    logic [1:0]  reg_sel = '0;
    logic [15:0] reg_data = '0;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        dma_status, done_pulse, aborted, bus_req, bus_we;
    logic [15:0] remaining, bus_addr, bus_wdata;

    dma_copy_engine #(.ADDR_STEP(16'd2)) dut (
        .clk(clk), .rst(rst), .en_i(en),
        .reg_wr_en_i(reg_wr_en), .reg_sel_i(reg_sel), .reg_data_i(reg_data),
        .dma_status_o(dma_status), .done_pulse_o(done_pulse), .aborted_o(aborted),
        .remaining_o(remaining), .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t obs_q[$];
    txn_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int wait_n = 0;
    int wcnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_busy = 0;
    int req_cnt = 0;
    int start_cyc = 0;
    int m_rem = 0;
    int m_len = 0;
    bit chk_en = 1'b0;
    bit prev_wait = 1'b0;
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Copy model: word i reads src + i*2 (or src when fixed), writes dst likewise.
    function automatic void build_exp(input logic [15:0] src, input logic [15:0] dst,
                                      input int n, input bit sfix, input bit dfix);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [15:0] ra, wa;
            ra = sfix ? src : 16'(src + 16'(2 * i));
            wa = dfix ? dst : 16'(dst + 16'(2 * i));
            exp_q.push_back('{we: 1'b0, addr: ra, data: mem_val(ra)});
            exp_q.push_back('{we: 1'b1, addr: wa, data: mem_val(ra)});
        end
    endfunction

    function automatic void check_txns(input string tag);
        chk({tag, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                chk({tag, "_txn_we"},   32'(obs_q[i].we),   32'(exp_q[i].we));
                chk({tag, "_txn_addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
                chk({tag, "_txn_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
            end
        end
    endfunction

    function automatic logic [31:0] obs_addr(input int i);
        return (i < obs_q.size()) ? 32'(obs_q[i].addr) : 32'hFFFF_FFFF;
    endfunction

    // Bus memory model plus per-cycle compare, all at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (done_pulse) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = int'(dma_status);
            end
            if (bus_req) req_cnt++;
            if (chk_en) begin
                chk("remaining", 32'(remaining), 32'(m_rem));
                if (bus_req) chk("busy_with_req", 32'(dma_status), 32'd1);
                if (prev_wait && bus_req) begin
                    chk("hold_we",    32'(bus_we),    32'(prev_we));
                    chk("hold_addr",  32'(bus_addr),  32'(prev_addr));
                    chk("hold_wdata", 32'(bus_wdata), 32'(prev_wdata));
                end
            end
            if (bus_ack || !bus_req) wcnt = 0;
            prev_wait = 1'b0;
            bus_ack   = 1'b0;
            bus_rdata = 16'hDEAD;
            if (bus_req && en && !rst) begin
                if (wcnt >= wait_n) begin
                    bus_ack = 1'b1;
                    if (bus_we) begin
                        obs_q.push_back('{we: 1'b1, addr: bus_addr, data: bus_wdata});
                        m_rem--;
                    end else begin
                        bus_rdata = mem_val(bus_addr);
                        obs_q.push_back('{we: 1'b0, addr: bus_addr, data: bus_rdata});
                    end
                end else begin
                    wcnt++;
                end
            end
            if (bus_req && !bus_ack) begin
                prev_wait  = 1'b1;
                prev_we    = bus_we;
                prev_addr  = bus_addr;
                prev_wdata = bus_wdata;
            end
        end
    end

    task automatic reg_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        reg_wr_en = 1'b1;
        reg_sel   = sel;
        reg_data  = data;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic configure(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        reg_write(REG_SRC, src);
        reg_write(REG_DST, dst);
        reg_write(REG_LEN, len);
        m_len = int'(len);
    endtask

    task automatic start(input logic [15:0] ctrl);
        obs_q.delete();
        reg_write(REG_CTRL, ctrl);
        start_cyc = cyc;
        m_rem     = m_len;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < maxc) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        #1;
    endtask

    initial begin
        int snap_req, snap_done;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status",  32'(dma_status), 32'd0);
        chk("rst_done",    32'(done_pulse), 32'd0);
        chk("rst_aborted", 32'(aborted),    32'd0);
        chk("rst_remain",  32'(remaining),  32'd0);
        chk("rst_req",     32'(bus_req),    32'd0);
        chk("rst_we",      32'(bus_we),     32'd0);
        chk("rst_addr",    32'(bus_addr),   32'd0);
        chk("rst_wdata",   32'(bus_wdata),  32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Basic 3-word copy, zero-wait bus
        wait_n = 0;
        configure(16'h1000, 16'h2000, 16'd3);
        build_exp(16'h1000, 16'h2000, 3, 1'b0, 1'b0);
        start(16'h0001);
        wait_done("t1", 50);
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd7);
        chk("t1_busy_at_done", 32'(done_busy), 32'd0);
        check_txns("t1");
        chk("t1_pin_w0_addr", obs_addr(1), 32'h2000);
        chk("t1_pin_w0_data", (obs_q.size() > 1) ? 32'(obs_q[1].data) : 32'hFFFF_FFFF, 32'h4A3C);
        chk("t1_pin_r2_addr", obs_addr(4), 32'h1004);
        chk("t1_aborted", 32'(aborted), 32'd0);
        chk("t1_status",  32'(dma_status), 32'd0);

        // Zero-length transfer
        configure(16'h1000, 16'h2000, 16'd0);
        snap_req = req_cnt;
        start(16'h0001);
        wait_done("t2", 20);
        chk("t2_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        chk("t2_no_req", 32'(req_cnt - snap_req), 32'd0);
        chk("t2_aborted", 32'(aborted), 32'd0);

        // Fixed source, 3 wait states per transaction
        wait_n = 3;
        configure(16'hFF02, 16'h3000, 16'd2);
        build_exp(16'hFF02, 16'h3000, 2, 1'b1, 1'b0);
        start(16'h0003);
        wait_done("t3", 100);
        check_txns("t3");
        chk("t3_pin_r1_addr", obs_addr(2), 32'hFF02);
        chk("t3_remain", 32'(remaining), 32'd0);

        // Abort during the first read of a 5-word copy
        wait_n = 1;
        configure(16'h4000, 16'h5000, 16'd5);
        build_exp(16'h4000, 16'h5000, 1, 1'b0, 1'b0);
        snap_done = done_cnt;
        start(16'h0001);
        reg_write(REG_CTRL, 16'h0008);
        wait_done("t4", 60);
        check_txns("t4");
        chk("t4_aborted", 32'(aborted),   32'd1);
        chk("t4_remain",  32'(remaining), 32'd4);
        snap_req = req_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("t4_no_more_req", 32'(req_cnt - snap_req), 32'd0);
        chk("t4_one_done",    32'(done_cnt - snap_done), 32'd1);

        // Destination wrap; LEN write while busy must be ignored
        wait_n = 0;
        configure(16'h6000, 16'hFFFE, 16'd2);
        build_exp(16'h6000, 16'hFFFE, 2, 1'b0, 1'b0);
        start(16'h0001);
        reg_write(REG_LEN, 16'd7);
        wait_done("t5", 50);
        check_txns("t5");
        chk("t5_pin_w0_addr", obs_addr(1), 32'hFFFE);
        chk("t5_pin_w1_addr", obs_addr(3), 32'h0000);
        chk("t5_aborted", 32'(aborted), 32'd0);

        // Rerun with same LEN (still 2) and a 4-cycle clock-enable gap
        start(16'h0001);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        en = 1'b1;
        wait_done("t6", 50);
        chk("t6_done_latency", 32'(done_cyc - start_cyc), 32'd9);
        check_txns("t6");

        // Reset mid-transfer
        snap_done = done_cnt;
        start(16'h0001);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst    = 1'b1;
        m_rem  = 0;
        @(posedge clk);
        #1;
        chk("t7_req",     32'(bus_req),    32'd0);
        chk("t7_status",  32'(dma_status), 32'd0);
        chk("t7_remain",  32'(remaining),  32'd0);
        chk("t7_aborted", 32'(aborted),    32'd0);
        chk("t7_addr",    32'(bus_addr),   32'd0);
        chk("t7_we",      32'(bus_we),     32'd0);
        chk("t7_wdata",   32'(bus_wdata),  32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t7_no_done", 32'(done_cnt - snap_done), 32'd0);
        chk("t7_idle_req", 32'(bus_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
